// File: rtl/riscv_bp_pkg.sv
// riscv_bp_pkg: shared types for the branch predictor table controller.
// Holds the 2-bit counter encodings and the controller FSM state type.
package riscv_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b11,
    ST  = 2'b10
  } bp_pred_e;

  typedef enum logic {
    BP_CLEAR = 1'b0,
    BP_IDLE  = 1'b1
  } bp_state_e;

endpackage

// File: rtl/riscv_bp_ctrl_if.sv
// riscv_bp_ctrl_if: branch-unit update bus plus prediction-table write port.
// master = branch unit / table side, slave = riscv_bp_ctrl.
interface riscv_bp_ctrl_if #(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int ADR_BITS       = 12
) ();

  logic                      bu_bp_update_i;
  logic [XLEN-1:0]           bu_ex_pc_i;
  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i;
  logic [1:0]                bu_bp_new_predict_i;
  logic [ADR_BITS-1:0]       ram_waddr_o;
  logic [1:0]                ram_din_o;
  logic                      ram_we_o;

  modport master (
    output bu_bp_update_i,
    output bu_ex_pc_i,
    output bu_bp_history_i,
    output bu_bp_new_predict_i,
    input  ram_waddr_o,
    input  ram_din_o,
    input  ram_we_o
  );

  modport slave (
    input  bu_bp_update_i,
    input  bu_ex_pc_i,
    input  bu_bp_history_i,
    input  bu_bp_new_predict_i,
    output ram_waddr_o,
    output ram_din_o,
    output ram_we_o
  );

endinterface

// File: rtl/riscv_bp_upd_fifo.sv
// riscv_bp_upd_fifo: 2-entry update queue with flush.
// Ports: push_i/din_i in, pop_i/dout_o out, full_o/empty_o status, flush_i clear.
module riscv_bp_upd_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign dout_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A full queue still accepts a push when the head leaves this cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      // Same-cycle push survives the flush as the only entry.
      if (push_i) mem_q[0] <= din_i;
      wptr_q <= push_i;
      rptr_q <= 1'b0;
      cnt_q  <= {1'b0, push_i};
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/riscv_bp_ctrl.sv
// riscv_bp_ctrl: clears the prediction table and serialises branch updates.
// Ports: clk_i/rst_i, flush_i, bus (update in, table write out), busy_o, predict_valid_o, dropped_o.
module riscv_bp_ctrl
  import riscv_bp_pkg::*;
#(
  parameter int         XLEN              = 32,
  parameter int         BP_GLOBAL_BITS    = 2,
  parameter int         BP_LOCAL_BITS     = 10,
  parameter int         BP_LOCAL_BITS_LSB = 2,
  parameter logic [1:0] INIT_PREDICTION   = WNT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  riscv_bp_ctrl_if.slave  bus,
  output logic            busy_o,
  output logic            predict_valid_o,
  output logic            dropped_o
);

  localparam int ADR_BITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam int EW       = ADR_BITS + 2;
  localparam logic [ADR_BITS:0] CNT_ONE = (ADR_BITS+1)'(1);

  bp_state_e             state_q, state_d;
  // Extra MSB marks "all addresses issued"; last write is then on the port.
  logic [ADR_BITS:0]     cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADR_BITS-1:0]   waddr_q, waddr_d;
  logic [1:0]            din_q, din_d;
  logic                  drop_q, drop_d;

  logic [ADR_BITS-1:0]   upd_addr;
  logic [EW-1:0]         head;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  unused_pc;

  assign upd_addr  = {bus.bu_bp_history_i,
                      bus.bu_ex_pc_i[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS]};
  assign unused_pc = ^bus.bu_ex_pc_i;
  assign pop       = (state_q == BP_IDLE) & ~empty & ~flush_i;

  riscv_bp_upd_fifo #(
    .W (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (bus.bu_bp_update_i),
    .pop_i   (pop),
    .din_i   ({upd_addr, bus.bu_bp_new_predict_i}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BP_CLEAR;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      drop_q  <= drop_d;
    end
  end

  // Flush issues address 0 right away, so the counter resumes at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    priority case (1'b1)
      flush_i: begin
        state_d = BP_CLEAR;
        cnt_d   = CNT_ONE;
      end
      (state_q == BP_CLEAR): begin
        if (!cnt_q[ADR_BITS]) cnt_d = cnt_q + CNT_ONE;
        else                  state_d = BP_IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    priority case (1'b1)
      flush_i: begin
        we_d    = 1'b1;
        waddr_d = '0;
        din_d   = INIT_PREDICTION;
      end
      ((state_q == BP_CLEAR) && !cnt_q[ADR_BITS]): begin
        we_d    = 1'b1;
        waddr_d = cnt_q[ADR_BITS-1:0];
        din_d   = INIT_PREDICTION;
      end
      pop: begin
        we_d    = 1'b1;
        waddr_d = head[EW-1:2];
        din_d   = head[1:0];
      end
      default: ;
    endcase
    drop_d = bus.bu_bp_update_i & full & ~pop & ~flush_i;
  end

  assign bus.ram_we_o    = we_q;
  assign bus.ram_waddr_o = waddr_q;
  assign bus.ram_din_o   = din_q;
  assign busy_o          = (state_q == BP_CLEAR);
  assign predict_valid_o = ~busy_o;
  assign dropped_o       = drop_q;

endmodule

// File: tb/tb_riscv_bp_ctrl.sv
// tb_riscv_bp_ctrl: directed bench for riscv_bp_ctrl (16-entry table).
// Drives and samples on the falling edge; expected values are hand-computed.
module tb_riscv_bp_ctrl;

  localparam int G   = 1;
  localparam int L   = 3;
  localparam int ADR = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  logic busy;
  logic pv;
  logic dropped;
  int   checks = 0;
  int   errors = 0;

  riscv_bp_ctrl_if #(
    .XLEN (32), .BP_GLOBAL_BITS (G), .ADR_BITS (ADR)
  ) bus ();

  riscv_bp_ctrl #(
    .XLEN (32), .BP_GLOBAL_BITS (G), .BP_LOCAL_BITS (L),
    .BP_LOCAL_BITS_LSB (2), .INIT_PREDICTION (2'b01)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .bus             (bus),
    .busy_o          (busy),
    .predict_valid_o (pv),
    .dropped_o       (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic v, input logic [31:0] pc,
                     input logic [G-1:0] h, input logic [1:0] d);
    bus.bu_bp_update_i      = v;
    bus.bu_ex_pc_i          = pc;
    bus.bu_bp_history_i     = h;
    bus.bu_bp_new_predict_i = d;
  endtask

  task automatic wr(input string tag, input logic we,
                    input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(bus.ram_we_o), 32'(we));
    if (we) begin
      chk({tag, "_addr"}, 32'(bus.ram_waddr_o), a);
      chk({tag, "_din"}, 32'(bus.ram_din_o), d);
    end
  endtask

  task automatic sweep(input string tag, input int lo, input int hi);
    for (int j = lo; j <= hi; j++) begin
      @(negedge clk);
      wr(tag, 1'b1, 32'(j), 32'h1);
      chk({tag, "_busy"}, 32'(busy), 32'h1);
    end
  endtask

  task automatic rst_vals(input string tag);
    wr(tag, 1'b0, 0, 0);
    chk({tag, "_addr"}, 32'(bus.ram_waddr_o), 32'h0);
    chk({tag, "_din"}, 32'(bus.ram_din_o), 32'h0);
    chk({tag, "_drop"}, 32'(dropped), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h1);
    chk({tag, "_pv"}, 32'(pv), 32'h0);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_pv"}, 32'(pv), 32'h1);
    wr(tag, 1'b0, 0, 0);
  endtask

  // Four back-to-back updates: pc bits [4:2] plus history form the address.
  logic [31:0]  vpc [4] = '{32'h0000_0000, 32'h1000_0004, 32'h0000_0008, 32'h0000_003C};
  logic [G-1:0] vh  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0]   vd  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [31:0]  va  [4] = '{32'h0, 32'h1, 32'hA, 32'h7};

  // Updates during a sweep; the third one finds the queue full.
  logic [31:0]  upc [3] = '{32'h08, 32'h14, 32'h0C};
  logic [G-1:0] uh  [3] = '{1'b0, 1'b1, 1'b1};
  logic [1:0]   ud  [3] = '{2'b10, 2'b00, 2'b11};

  initial begin
    upd(1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_vals("rst");

    rst = 1'b0;
    sweep("init", 0, 15);
    @(negedge clk);
    idle_chk("init_done");

    upd(1'b1, 32'h1C, 1'b1, 2'b11);
    @(negedge clk);
    upd(1'b0, 0, 0, 0);
    wr("lat_k", 1'b0, 0, 0);
    @(negedge clk);
    wr("lat_k1", 1'b1, 32'hF, 32'h3);
    @(negedge clk);
    wr("lat_after", 1'b0, 0, 0);

    for (int i = 0; i <= 4; i++) begin
      if (i < 4) upd(1'b1, vpc[i], vh[i], vd[i]);
      else       upd(1'b0, 0, 0, 0);
      @(negedge clk);
      if (i >= 1) wr("b2b", 1'b1, va[i-1], 32'(vd[i-1]));
      else        wr("b2b_first", 1'b0, 0, 0);
      chk("b2b_drop", 32'(dropped), 32'h0);
    end
    @(negedge clk);
    wr("b2b_end", 1'b0, 0, 0);

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wr("fl_idle", 1'b1, 32'h0, 32'h1);
    chk("fl_idle_busy", 32'(busy), 32'h1);
    for (int j = 1; j <= 15; j++) begin
      if (j <= 3) upd(1'b1, upc[j-1], uh[j-1], ud[j-1]);
      else        upd(1'b0, 0, 0, 0);
      @(negedge clk);
      wr("clr_upd", 1'b1, 32'(j), 32'h1);
      chk("clr_drop", 32'(dropped), 32'(j == 3));
    end
    @(negedge clk);
    idle_chk("clr_done");
    @(negedge clk);
    wr("clr_q0", 1'b1, 32'h2, 32'h2);
    @(negedge clk);
    wr("clr_q1", 1'b1, 32'hD, 32'h0);
    @(negedge clk);
    wr("clr_q_end", 1'b0, 0, 0);

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wr("fl9_start", 1'b1, 32'h0, 32'h1);
    for (int j = 1; j <= 8; j++) begin
      if (j == 1)      upd(1'b1, 32'h04, 1'b0, 2'b11);
      else if (j == 2) upd(1'b1, 32'h18, 1'b1, 2'b10);
      else             upd(1'b0, 0, 0, 0);
      @(negedge clk);
      wr("fl9_pre", 1'b1, 32'(j), 32'h1);
    end
    flush = 1'b1;
    upd(1'b1, 32'h10, 1'b0, 2'b00);
    @(negedge clk);
    flush = 1'b0;
    upd(1'b0, 0, 0, 0);
    wr("fl9_restart", 1'b1, 32'h0, 32'h1);
    chk("fl9_drop", 32'(dropped), 32'h0);
    chk("fl9_busy", 32'(busy), 32'h1);
    sweep("fl9_sweep", 1, 15);
    @(negedge clk);
    idle_chk("fl9_done");
    @(negedge clk);
    wr("fl9_kept", 1'b1, 32'h4, 32'h0);
    @(negedge clk);
    wr("fl9_end", 1'b0, 0, 0);

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wr("mr_start", 1'b1, 32'h0, 32'h1);
    for (int j = 1; j <= 5; j++) begin
      if (j == 2) upd(1'b1, 32'h0, 1'b1, 2'b11);
      else        upd(1'b0, 0, 0, 0);
      @(negedge clk);
      wr("mr_pre", 1'b1, 32'(j), 32'h1);
    end
    upd(1'b0, 0, 0, 0);
    rst = 1'b1;
    #1;
    rst_vals("mr_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sweep("mr_sweep", 0, 15);
    @(negedge clk);
    idle_chk("mr_done");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wr("mr_fifo_empty", 1'b0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
